stim_pulse_sequencer: RTL

STIM_PULSE_SEQUENCER -- requirements
Module: stim_pulse_sequencer

---
 rtl/stim_pulse_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/stim_pulse_sequencer.sv
// Biphasic stimulation pulse sequencer: cathodic/IPD/anodic/discharge/rest phases with channel sweep.
// Define ST_RAMP_EN to compile in the per-pulse amplitude ramp; otherwise RAMP is ignored.
//
// state | meaning
// IDLE  | no stimulation, waiting for ENABLE
// CAT   | cathodic phase, max(1, CAT_LEN) cycles
// IPD   | inter-pulse delay, skipped when IPD_LEN = 0
// ANO   | anodic phase, max(1, ANO_LEN) cycles
// DIS   | electrode discharge, skipped when DIS_LEN = 0
// REST  | remainder of the period, at least one cycle
module stim_pulse_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int MAG_W  = 5,
    parameter int CNT_W  = 16,
    parameter int DUR_CH = 5
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             ENABLE,
    input  logic             RAMP,
    input  logic             CH_SWEEP,
    input  logic [CNT_W-1:0] CAT_LEN,
    input  logic [CNT_W-1:0] IPD_LEN,
    input  logic [CNT_W-1:0] ANO_LEN,
    input  logic [CNT_W-1:0] DIS_LEN,
    input  logic [CNT_W-1:0] PERIOD_LEN,
    input  logic [MAG_W-1:0] MAG_TARGET,
    input  logic [CH_W-1:0]  CH_UP,
    input  logic [CH_W-1:0]  CH_DOWN,
    output logic             EN_ST,
    output logic             CAT_ST,
    output logic             ANO_ST,
    output logic             DIS_ST,
    output logic [CH_W-1:0]  CH_SEL_U_ST,
    output logic [CH_W-1:0]  CH_SEL_D_ST,
    output logic [MAG_W-1:0] MAG_ST,
    output logic             PULSE_DONE
);

    typedef enum logic [2:0] {S_IDLE, S_CAT, S_IPD, S_ANO, S_DIS, S_REST} state_t;

    localparam int SUM_W = CNT_W + 2;
    localparam int PC_W  = $clog2(DUR_CH + 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0] ipd_q, ano_q, dis_q, rest_q;
    logic [CNT_W-1:0] cat_eff_in, ano_eff_in, rest_in;
    logic [SUM_W-1:0] phase_sum, period_ext;
    logic             start, first, sweep_q;
    logic [PC_W-1:0]  pcnt_q, pcnt_nxt;
    logic [CH_W-1:0]  ch_u_nxt, ch_d_nxt;
    logic [MAG_W-1:0] mag_nxt;

    // Rest length is fixed at CAT entry; the wide sum cannot wrap even with all lengths at maximum.
    always_comb begin
        cat_eff_in = (CAT_LEN == '0) ? CNT_W'(1) : CAT_LEN;
        ano_eff_in = (ANO_LEN == '0) ? CNT_W'(1) : ANO_LEN;
        phase_sum  = SUM_W'(cat_eff_in) + SUM_W'(IPD_LEN) + SUM_W'(ano_eff_in) + SUM_W'(DIS_LEN);
        period_ext = {2'b00, PERIOD_LEN};
        rest_in    = (period_ext > phase_sum) ? CNT_W'(period_ext - phase_sum) : CNT_W'(1);
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    state_nxt = S_CAT;
                    cnt_nxt   = cat_eff_in - 1'b1;
                    start     = 1'b1;
                end
            end
            S_CAT: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else if (ipd_q != '0) begin
                    state_nxt = S_IPD;
                    cnt_nxt   = ipd_q - 1'b1;
                end else begin
                    state_nxt = S_ANO;
                    cnt_nxt   = ano_q - 1'b1;
                end
            end
            S_IPD: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else begin
                    state_nxt = S_ANO;
                    cnt_nxt   = ano_q - 1'b1;
                end
            end
            S_ANO: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else if (dis_q != '0) begin
                    state_nxt = S_DIS;
                    cnt_nxt   = dis_q - 1'b1;
                end else begin
                    state_nxt = S_REST;
                    cnt_nxt   = rest_q - 1'b1;
                end
            end
            S_DIS: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else begin
                    state_nxt = S_REST;
                    cnt_nxt   = rest_q - 1'b1;
                end
            end
            S_REST: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else if (ENABLE) begin
                    state_nxt = S_CAT;
                    cnt_nxt   = cat_eff_in - 1'b1;
                    start     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign first = (state_q == S_IDLE);

    // A sweep restarts from channel 0 whenever it begins afresh, not only after IDLE.
    always_comb begin
        ch_u_nxt = CH_UP;
        ch_d_nxt = CH_DOWN;
        pcnt_nxt = '0;
        if (CH_SWEEP) begin
            if (first || !sweep_q) begin
                ch_u_nxt = '0;
                pcnt_nxt = PC_W'(1);
            end else if (pcnt_q >= PC_W'(DUR_CH)) begin
                ch_u_nxt = (CH_SEL_U_ST == CH_LAST) ? '0 : CH_SEL_U_ST + 1'b1;
                pcnt_nxt = PC_W'(1);
            end else begin
                ch_u_nxt = CH_SEL_U_ST;
                pcnt_nxt = pcnt_q + 1'b1;
            end
            ch_d_nxt = (ch_u_nxt == CH_LAST) ? '0 : ch_u_nxt + 1'b1;
        end
    end

`ifdef ST_RAMP_EN
    always_comb begin
        mag_nxt = MAG_TARGET;
        if (RAMP) begin
            if (first)
                mag_nxt = (MAG_TARGET == '0) ? '0 : MAG_W'(1);
            else if (MAG_ST < MAG_TARGET)
                mag_nxt = MAG_ST + 1'b1;
        end
    end
`else
    logic unused_ramp;
    assign unused_ramp = RAMP;
    assign mag_nxt     = MAG_TARGET;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ipd_q       <= '0;
            ano_q       <= '0;
            dis_q       <= '0;
            rest_q      <= '0;
            sweep_q     <= 1'b0;
            pcnt_q      <= '0;
            EN_ST       <= 1'b0;
            CAT_ST      <= 1'b0;
            ANO_ST      <= 1'b0;
            DIS_ST      <= 1'b0;
            PULSE_DONE  <= 1'b0;
            CH_SEL_U_ST <= '0;
            CH_SEL_D_ST <= CH_W'(1);
            MAG_ST      <= '0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            EN_ST      <= (state_nxt != S_IDLE);
            CAT_ST     <= (state_nxt == S_CAT);
            ANO_ST     <= (state_nxt == S_ANO);
            DIS_ST     <= (state_nxt == S_DIS);
            PULSE_DONE <= (state_nxt == S_REST) && (cnt_nxt == '0);
            if (start) begin
                ipd_q       <= IPD_LEN;
                ano_q       <= ano_eff_in;
                dis_q       <= DIS_LEN;
                rest_q      <= rest_in;
                sweep_q     <= CH_SWEEP;
                pcnt_q      <= pcnt_nxt;
                CH_SEL_U_ST <= ch_u_nxt;
                CH_SEL_D_ST <= ch_d_nxt;
                MAG_ST      <= mag_nxt;
            end
        end
    end

endmodule
